// File: rtl/mode_switch_controller_if.sv
// Mode-switch bus: host request and engine status in, committed mode and gated controls out.
// The controller attaches through the slave modport and the host side through the master modport.
interface mode_switch_controller_if;
  logic [1:0] UsbModeSelect;
  logic       UsbStartStop;
  logic [3:0] SubsystemBusy;
  logic       UsbFifoEmpty;
  logic [1:0] ModeSelect;
  logic       GatedStartStop;
  logic       ForceReset;
  logic       SwitchBusy;
  logic       ModeChanged;
  logic       SwitchTimeout;

  modport slave (
    input  UsbModeSelect, UsbStartStop, SubsystemBusy, UsbFifoEmpty,
    output ModeSelect, GatedStartStop, ForceReset, SwitchBusy, ModeChanged, SwitchTimeout
  );

  modport master (
    output UsbModeSelect, UsbStartStop, SubsystemBusy, UsbFifoEmpty,
    input  ModeSelect, GatedStartStop, ForceReset, SwitchBusy, ModeChanged, SwitchTimeout
  );
endinterface

// File: rtl/mode_switch_controller.sv
// Sequences host mode changes: stop the engine, drain the FIFO, wait a guard interval, then commit.
// It also keeps host start levels away from the engines for the whole switch.
module mode_switch_controller #(
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                      Clk,
  input logic                      reset_n,
  mode_switch_controller_if.slave  sw
);

  localparam int unsigned CntW  = 16;
  localparam int unsigned ModeW = 2;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GuardLast   = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax      = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STOP   = 3'd1,
    DRAIN  = 3'd2,
    GUARD  = 3'd3,
    COMMIT = 3'd4
  } stateT;

  stateT            state, stateNext;
  logic [CntW-1:0]  cnt, cntNext;
  logic [ModeW-1:0] target, targetNext;
  logic [ModeW-1:0] modeSel, modeSelNext;
  logic             armed, armedNext;
  logic             gated, gatedNext;
  logic             forceRst, forceRstNext;
  logic             switchBusy, switchBusyNext;
  logic             changed, changedNext;
  logic             timeoutFlag, timeoutFlagNext;

  logic             activeBusy;
  logic             modeMismatch;
  logic [CntW-1:0]  cntInc;

  assign activeBusy   = sw.SubsystemBusy[modeSel];
  assign modeMismatch = (sw.UsbModeSelect != modeSel);
  // Saturating increment: the shared counter must never wrap.
  assign cntInc       = (cnt == CntMax) ? cnt : cnt + CntW'(1);

  // Next-state and registered-output values.
  always_comb begin
    stateNext       = state;
    cntNext         = cnt;
    targetNext      = target;
    modeSelNext     = modeSel;
    armedNext       = armed;
    timeoutFlagNext = timeoutFlag;
    forceRstNext    = 1'b0;
    changedNext     = 1'b0;

    case (state)
      IDLE: begin
        if (!sw.UsbStartStop) armedNext = 1'b1;
        if (modeMismatch) begin
          targetNext      = sw.UsbModeSelect;
          cntNext         = '0;
          timeoutFlagNext = 1'b0;
          stateNext       = STOP;
        end
      end
      STOP: begin
        // An engine going idle on the timeout cycle wins over the forced reset.
        if (!activeBusy) begin
          cntNext   = '0;
          stateNext = DRAIN;
        end else if (cnt == TimeoutLast) begin
          forceRstNext    = 1'b1;
          timeoutFlagNext = 1'b1;
          cntNext         = '0;
          stateNext       = DRAIN;
        end else begin
          cntNext = cntInc;
        end
      end
      DRAIN: begin
        // Stale FIFO data on timeout is left for the host to flush.
        if (sw.UsbFifoEmpty) begin
          cntNext   = '0;
          stateNext = GUARD;
        end else if (cnt == TimeoutLast) begin
          timeoutFlagNext = 1'b1;
          cntNext         = '0;
          stateNext       = GUARD;
        end else begin
          cntNext = cntInc;
        end
      end
      GUARD: begin
        if (cnt == GuardLast) begin
          cntNext   = '0;
          stateNext = COMMIT;
        end else begin
          cntNext = cntInc;
        end
      end
      COMMIT: begin
        modeSelNext = target;
        changedNext = 1'b1;
        armedNext   = 1'b0;
        cntNext     = '0;
        stateNext   = IDLE;
      end
      default: begin
        cntNext   = '0;
        stateNext = IDLE;
      end
    endcase

    switchBusyNext = (stateNext != IDLE);
    // Start passes only in a settled IDLE; it drops on the very edge that leaves IDLE.
    gatedNext      = sw.UsbStartStop & armed & (state == IDLE) & (stateNext == IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      target      <= '0;
      modeSel     <= '0;
      armed       <= 1'b0;
      gated       <= 1'b0;
      forceRst    <= 1'b0;
      switchBusy  <= 1'b0;
      changed     <= 1'b0;
      timeoutFlag <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      target      <= targetNext;
      modeSel     <= modeSelNext;
      armed       <= armedNext;
      gated       <= gatedNext;
      forceRst    <= forceRstNext;
      switchBusy  <= switchBusyNext;
      changed     <= changedNext;
      timeoutFlag <= timeoutFlagNext;
    end
  end

  assign sw.ModeSelect     = modeSel;
  assign sw.GatedStartStop = gated;
  assign sw.ForceReset     = forceRst;
  assign sw.SwitchBusy     = switchBusy;
  assign sw.ModeChanged    = changed;
  assign sw.SwitchTimeout  = timeoutFlag;

endmodule

// File: tb/tb_mode_switch_controller.sv
// Directed bench for mode_switch_controller: dutA uses default timing, dutB a short timeout/guard.
module tb_mode_switch_controller;
  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mode_switch_controller_if busA();
  mode_switch_controller_if busB();

  mode_switch_controller #(.GUARD_CYCLES(16), .TIMEOUT_CYCLES(65535)) dutA (
    .Clk(Clk), .reset_n(reset_n), .sw(busA)
  );
  mode_switch_controller #(.GUARD_CYCLES(4), .TIMEOUT_CYCLES(8)) dutB (
    .Clk(Clk), .reset_n(reset_n), .sw(busB)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    busA.UsbModeSelect = 2'b00; busA.UsbStartStop = 1'b0;
    busA.SubsystemBusy = 4'b0000; busA.UsbFifoEmpty = 1'b1;
    busB.UsbModeSelect = 2'b00; busB.UsbStartStop = 1'b0;
    busB.SubsystemBusy = 4'b0000; busB.UsbFifoEmpty = 1'b1;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    idleInputs();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic checkResetA(input string tag);
    checkVal({tag, "_mode"}, busA.ModeSelect, 0);
    checkVal({tag, "_gated"}, busA.GatedStartStop, 0);
    checkVal({tag, "_frst"}, busA.ForceReset, 0);
    checkVal({tag, "_busy"}, busA.SwitchBusy, 0);
    checkVal({tag, "_chg"}, busA.ModeChanged, 0);
    checkVal({tag, "_tmo"}, busA.SwitchTimeout, 0);
  endtask

  initial begin
    // Reset values and start pass-through in IDLE.
    idleInputs();
    reset_n = 1'b0;
    tick(); tick();
    checkResetA("rst");
    checkVal("rstB_mode", busB.ModeSelect, 0);
    checkVal("rstB_busy", busB.SwitchBusy, 0);
    reset_n = 1'b1;
    tick();
    busA.UsbStartStop = 1'b1;
    tick();
    checkVal("t1_gated_hi", busA.GatedStartStop, 1);
    checkVal("t1_mode", busA.ModeSelect, 0);
    checkVal("t1_busy", busA.SwitchBusy, 0);
    busA.UsbStartStop = 1'b0;
    tick();
    checkVal("t1_gated_lo", busA.GatedStartStop, 0);

    // Minimum-latency switch 00 -> 01.
    resetDut();
    busA.UsbModeSelect = 2'b01;
    for (int k = 1; k <= 21; k++) begin
      tick();
      checkVal($sformatf("t2_busy@%0d", k), busA.SwitchBusy, (k < 20));
      checkVal($sformatf("t2_mode@%0d", k), busA.ModeSelect, (k >= 20) ? 1 : 0);
      checkVal($sformatf("t2_chg@%0d", k), busA.ModeChanged, (k == 20));
      checkVal($sformatf("t2_frst@%0d", k), busA.ForceReset, 0);
    end

    // Busy engine for 100 cycles, then FIFO non-empty for 50 more; start held.
    resetDut();
    busA.UsbStartStop = 1'b1;
    tick();
    checkVal("t3_gated_pre", busA.GatedStartStop, 1);
    busA.SubsystemBusy = 4'b0001;
    busA.UsbFifoEmpty  = 1'b0;
    busA.UsbModeSelect = 2'b10;
    for (int k = 1; k <= 170; k++) begin
      tick();
      checkVal($sformatf("t3_gated@%0d", k), busA.GatedStartStop, 0);
      if (k == 100) busA.SubsystemBusy = 4'b0000;
      if (k == 150) busA.UsbFifoEmpty = 1'b1;
      if (k == 167) begin
        checkVal("t3_mode_pre", busA.ModeSelect, 0);
        checkVal("t3_busy_pre", busA.SwitchBusy, 1);
      end
      if (k == 168) begin
        checkVal("t3_mode", busA.ModeSelect, 2);
        checkVal("t3_chg", busA.ModeChanged, 1);
        checkVal("t3_busy", busA.SwitchBusy, 0);
      end
    end
    checkVal("t3_tmo", busA.SwitchTimeout, 0);

    // STOP timeout with forced reset, then DRAIN timeout without one.
    resetDut();
    busB.SubsystemBusy = 4'b0001;
    busB.UsbModeSelect = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkVal($sformatf("t4_frst@%0d", k), busB.ForceReset, (k == 9));
      checkVal($sformatf("t4_tmo@%0d", k), busB.SwitchTimeout, (k >= 9));
      checkVal($sformatf("t4_mode@%0d", k), busB.ModeSelect, (k >= 15) ? 3 : 0);
      checkVal($sformatf("t4_chg@%0d", k), busB.ModeChanged, (k == 15));
    end
    busB.UsbFifoEmpty  = 1'b0;
    busB.UsbModeSelect = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkVal($sformatf("t4d_frst@%0d", k), busB.ForceReset, 0);
      checkVal($sformatf("t4d_tmo@%0d", k), busB.SwitchTimeout, (k >= 10));
      checkVal($sformatf("t4d_mode@%0d", k), busB.ModeSelect, (k >= 15) ? 0 : 3);
    end

    // Start held across a switch must be re-armed by a low level.
    resetDut();
    busA.UsbStartStop = 1'b1;
    tick();
    checkVal("t5_gated_pre", busA.GatedStartStop, 1);
    busA.UsbModeSelect = 2'b01;
    for (int k = 1; k <= 25; k++) begin
      tick();
      checkVal($sformatf("t5_gated@%0d", k), busA.GatedStartStop, 0);
    end
    checkVal("t5_mode", busA.ModeSelect, 1);
    busA.UsbStartStop = 1'b0;
    tick();
    checkVal("t5_gated_low", busA.GatedStartStop, 0);
    busA.UsbStartStop = 1'b1;
    tick();
    checkVal("t5_gated_rearm", busA.GatedStartStop, 1);

    // Request changed during GUARD: commit 01, then a second switch to 10.
    resetDut();
    busA.UsbModeSelect = 2'b01;
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k == 5) busA.UsbModeSelect = 2'b10;
      if (k == 19) checkVal("t6_mode19", busA.ModeSelect, 0);
      if (k == 20) begin
        checkVal("t6_mode20", busA.ModeSelect, 1);
        checkVal("t6_chg20", busA.ModeChanged, 1);
        checkVal("t6_busy20", busA.SwitchBusy, 0);
      end
      if (k == 21) checkVal("t6_busy21", busA.SwitchBusy, 1);
      if (k == 39) checkVal("t6_mode39", busA.ModeSelect, 1);
      if (k == 40) begin
        checkVal("t6_mode40", busA.ModeSelect, 2);
        checkVal("t6_chg40", busA.ModeChanged, 1);
      end
      if (k == 41) checkVal("t6_busy41", busA.SwitchBusy, 0);
    end

    // Reset asserted while in DRAIN aborts to reset values.
    resetDut();
    busA.UsbModeSelect = 2'b01;
    busA.UsbFifoEmpty  = 1'b0;
    tick(); tick(); tick();
    checkVal("t7_busy_pre", busA.SwitchBusy, 1);
    reset_n = 1'b0;
    #1;
    checkResetA("t7_rst");
    busA.UsbModeSelect = 2'b00;
    busA.UsbFifoEmpty  = 1'b1;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    checkVal("t7_mode_after", busA.ModeSelect, 0);
    checkVal("t7_busy_after", busA.SwitchBusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mode_switch_controller.md
# mode_switch_controller

Sequences changes of the board operating mode (ACQ 00, SCURVE 01, SWEEP_ACQ 10, ADC 11) that drives the mode multiplexer between the USB command decoder and the acquisition, S-curve, sweep and ADC engines. A host-requested mode change must never be applied while an engine is running or the USB FIFO holds data. The block therefore does the following:

- stops the active engine;
- waits for it to go idle, with a timeout and forced reset;
- drains the FIFO;
- inserts a guard interval, then commits the new `ModeSelect`.

It also gates the USB start/stop level so that no start reaches any engine during a switch.

## Interface
Parameters:
- `GUARD_CYCLES`, 16: quiet cycles between drain complete and commit; legal range 1..65535.
- `TIMEOUT_CYCLES`, 65535: maximum cycles spent in STOP and in DRAIN; legal range 1..65535.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `UsbModeSelect`  in  2  host-requested mode (level).
- `UsbStartStop`  in  1  host start/stop level for the active mode.
- `SubsystemBusy`  in  4  engine busy flags; bit index = mode code.
- `UsbFifoEmpty`  in  1  USB FIFO empty flag.
- `ModeSelect`  out  2  committed mode; drives the mode multiplexer.
- `GatedStartStop`  out  1  start/stop forwarded to the multiplexer.
- `ForceReset`  out  1  one-cycle pulse to force-reset the active engine on STOP timeout.
- `SwitchBusy`  out  1  high in every state except IDLE.
- `ModeChanged`  out  1  one-cycle pulse on commit.
- `SwitchTimeout`  out  1  sticky flag; set when STOP or DRAIN times out.

## Operation
States: IDLE, STOP, DRAIN, GUARD, COMMIT. Transitions:

- **IDLE**
  - When `UsbModeSelect != ModeSelect`: latch the target (= `UsbModeSelect`), clear the counter, clear `SwitchTimeout`, go to STOP.
- **STOP**
  - `GatedStartStop` is forced 0.
  - If `SubsystemBusy[ModeSelect] == 0`: clear the counter, go to DRAIN.
  - Otherwise, if counter == `TIMEOUT_CYCLES-1`: pulse `ForceReset`, set `SwitchTimeout`, clear the counter, go to DRAIN.
  - Otherwise: increment the counter.
- **DRAIN**
  - If `UsbFifoEmpty`: clear the counter, go to GUARD.
  - On timeout (same count rule as STOP): set `SwitchTimeout`, go to GUARD. No `ForceReset` is issued; the host flushes stale data.
- **GUARD**
  - Count `GUARD_CYCLES` cycles (counter reaches `GUARD_CYCLES-1`), then go to COMMIT.
  - Busy and empty flags are ignored in GUARD.
- **COMMIT**
  - `ModeSelect` <= latched target; pulse `ModeChanged`; go to IDLE.

Rules:
- Counter: 16 bits, unsigned, shared by STOP, DRAIN and GUARD; never wraps; cleared on every state entry.
- `UsbModeSelect` changes during a switch are ignored. The latched target is committed; IDLE then compares again and starts a further switch on the next cycle if the request still differs. This applies even if the request has returned to the original mode.
- Start gating:
  - An internal `armed` flag is 0 after reset and after COMMIT.
  - `armed` is set when `UsbStartStop == 0` is sampled in IDLE.
  - `GatedStartStop` (registered) = `UsbStartStop & armed & (state == IDLE)`.
  - Consequence: a start level held across a switch does not start the new mode's engine until the host drops it and reasserts it.
- `SwitchBusy` (registered) = (next state != IDLE).

## Timing
- Reset values: `ModeSelect` = 00, `GatedStartStop` = 0, `ForceReset` = 0, `SwitchBusy` = 0, `ModeChanged` = 0, `SwitchTimeout` = 0, state = IDLE, counter = 0, `armed` = 0.
- Asserting `reset_n` low mid-switch aborts immediately to the reset values. `ModeSelect` returns to 00, not to the target.
- All outputs are registered. `GatedStartStop` follows `UsbStartStop` with 1-cycle latency in IDLE.
- Mismatch seen at edge N gives STOP at N+1.
- Minimum latency, with engine idle and FIFO empty: `SwitchBusy` rises at edge N+1 and `ModeSelect` updates at edge N+4+`GATE_CYCLES`, where `GATE_CYCLES` = `GUARD_CYCLES`.
  - Path: STOP at N+1, DRAIN at N+2, GUARD at N+3, COMMIT at N+3+`GUARD_CYCLES`, `ModeSelect` / `ModeChanged` at N+4+`GUARD_CYCLES`.
- In the same edge as commit, `SwitchBusy` falls.
- `GatedStartStop` drops to 0 at the edge that enters STOP (N+1).
- `ForceReset` is high exactly one cycle, at the edge leaving STOP on timeout.
- A busy flag deasserting in the same cycle as the timeout count takes priority: it is treated as idle, and no `ForceReset` is issued.

## Test plan
- Reset, `UsbModeSelect` = 00, `UsbStartStop` 0→1 → `GatedStartStop` = 1 one cycle later; `ModeSelect` stays 00; `SwitchBusy` stays 0.
- `ModeSelect` 00, request 01, all busy 0, FIFO empty, `GUARD_CYCLES` = 16 → `SwitchBusy` high 20 cycles; `ModeSelect` = 01 and `ModeChanged` pulse 20 cycles after request; no `ForceReset`.
- Request 10 while `SubsystemBusy[0]` = 1 for 100 cycles and FIFO non-empty a further 50 cycles → commit occurs only after both clear; `GatedStartStop` held 0 throughout; `SwitchTimeout` = 0.
- `TIMEOUT_CYCLES` = 8, `SubsystemBusy[0]` stuck 1, request 11 → `ForceReset` one-cycle pulse after 8 STOP cycles; `SwitchTimeout` = 1; `ModeSelect` = 11 after guard.
- `UsbStartStop` held 1 across a 00→01 switch → `GatedStartStop` stays 0 after commit until `UsbStartStop` goes 0 then 1.
- Request 01, then change to 10 during GUARD; separately, pulse `reset_n` low during DRAIN → first case commits 01 then performs a second switch to 10; reset case returns `ModeSelect` to 00 with all outputs at reset values.
